// File: rtl/issue_sequencer_pkg.sv
// rtl/issue_sequencer_pkg.sv - opcode map, instruction classes and decode helper for the issue sequencer
package issue_sequencer_pkg;

    localparam logic [3:0] OP_LDM = 4'h0;
    localparam logic [3:0] OP_STM = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_DIV = 4'hC;

    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_RS1     = 2'd1,
        SRC_RS1_RS2 = 2'd2
    } src_use_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DIV_BUSY = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic     legal;
        src_use_e src;
        logic     reg_write;
        logic     mem_write;
        logic     is_div;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [3:0] op);
        op_info_t info;
        info.legal     = 1'b1;
        info.src       = SRC_NONE;
        info.reg_write = 1'b1;
        info.mem_write = 1'b0;
        info.is_div    = 1'b0;
        case (op)
            OP_LDM: info.src = SRC_RS1;
            OP_STM: begin
                info.src       = SRC_RS1_RS2;
                info.reg_write = 1'b0;
                info.mem_write = 1'b1;
            end
            OP_LDR: info.src = SRC_NONE;
            OP_MOV, OP_NOT, OP_SHL, OP_SHR: info.src = SRC_RS1;
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: info.src = SRC_RS1_RS2;
            OP_DIV: begin
                info.src    = SRC_RS1_RS2;
                info.is_div = 1'b1;
            end
            default: begin
                // Illegal opcodes touch nothing, so they can never stall on a hazard.
                info.legal     = 1'b0;
                info.reg_write = 1'b0;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register pending bits with set/clear and hazard lookup
module issue_scoreboard
    import issue_sequencer_pkg::*;
#(
    parameter int NREG = 8,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [RA_W-1:0] set_rd,
    input  logic            clr_en,
    input  logic [RA_W-1:0] clr_rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] rd,
    output logic            rs1_pending,
    output logic            rs2_pending,
    output logic            rd_pending
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    // Set is applied after clear so a same-cycle issue to a retiring register stays pending.
    always_comb begin
        pending_next = pending;
        if (clr_en) pending_next[clr_rd] = 1'b0;
        if (set_en) pending_next[set_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

    // Lookups see only the registered bits; a writeback unblocks the following cycle.
    assign rs1_pending = pending[rs1];
    assign rs2_pending = pending[rs2];
    assign rd_pending  = pending[rd];

endmodule

// File: rtl/issue_sequencer.sv
// rtl/issue_sequencer.sv - in-order issue with RAW/WAW interlock and div occupancy; ISSUE_STALL_STATS_EN adds stall_count
module issue_sequencer
    import issue_sequencer_pkg::*;
#(
    parameter int NREG       = 8,
    parameter int RA_W       = 3,
    parameter int DIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [3:0]      id_opcode,
    input  logic [RA_W-1:0] id_rd,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    output logic            id_ready,
    output logic            ex_valid,
    output logic [3:0]      ex_opcode,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic            illegal_op,
    output logic            div_busy
`ifdef ISSUE_STALL_STATS_EN
    ,
    output logic [15:0]     stall_count
`endif
);

    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    op_info_t   info;
    seq_state_e state;
    seq_state_e state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       rs1_pending;
    logic       rs2_pending;
    logic       rd_pending;
    logic       use_rs1;
    logic       use_rs2;
    logic       accept;
    logic       issue;

    assign info    = decode_op(id_opcode);
    assign use_rs1 = (info.src != SRC_NONE);
    assign use_rs2 = (info.src == SRC_RS1_RS2);

    issue_scoreboard #(
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (issue && info.reg_write),
        .set_rd      (id_rd),
        .clr_en      (wb_valid),
        .clr_rd      (wb_rd),
        .rs1         (id_rs1),
        .rs2         (id_rs2),
        .rd          (id_rd),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .rd_pending  (rd_pending)
    );

    assign id_ready = (state == ST_IDLE)
                    && !(use_rs1 && rs1_pending)
                    && !(use_rs2 && rs2_pending)
                    && !(info.reg_write && rd_pending);
    assign accept   = id_valid && id_ready;
    assign issue    = accept && info.legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The acceptance cycle counts as the first div cycle, hence the DIV_CYCLES-1 load.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (issue && info.is_div) begin
                    state_next = ST_DIV_BUSY;
                    cnt_next   = DIV_LOAD;
                end
            end
            ST_DIV_BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= 4'd0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_write <= 1'b0;
            illegal_op   <= 1'b0;
            div_busy     <= 1'b0;
        end else begin
            ex_valid     <= issue;
            ex_reg_write <= issue && info.reg_write;
            ex_mem_write <= issue && info.mem_write;
            illegal_op   <= accept && !info.legal;
            div_busy     <= (state_next == ST_DIV_BUSY);
            if (issue) begin
                ex_opcode <= id_opcode;
                ex_rd     <= id_rd;
            end
        end
    end

`ifdef ISSUE_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                                                stall_count <= 16'd0;
        else if (id_valid && !id_ready && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_issue_sequencer.sv
// tb/tb_issue_sequencer.sv - self-checking scoreboard bench for issue_sequencer
module tb_issue_sequencer;

    localparam int NREG       = 8;
    localparam int RA_W       = 3;
    localparam int DIV_CYCLES = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [3:0]      id_opcode = 4'd0;
    logic [RA_W-1:0] id_rd = '0;
    logic [RA_W-1:0] id_rs1 = '0;
    logic [RA_W-1:0] id_rs2 = '0;
    logic            wb_valid = 1'b0;
    logic [RA_W-1:0] wb_rd = '0;
    logic            id_ready;
    logic            ex_valid;
    logic [3:0]      ex_opcode;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_write;
    logic            illegal_op;
    logic            div_busy;
`ifdef ISSUE_STALL_STATS_EN
    logic [15:0]     stall_count;
`endif

    issue_sequencer #(
        .NREG       (NREG),
        .RA_W       (RA_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .id_ready     (id_ready),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_write (ex_mem_write),
        .illegal_op   (illegal_op),
        .div_busy     (div_busy)
`ifdef ISSUE_STALL_STATS_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        logic [RA_W-1:0] rd;
        logic            rw;
        logic            mw;
    } ex_exp_t;

    ex_exp_t         exq[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [NREG-1:0] pend = '0;
    int              div_left = 0;
    logic            exp_ex = 1'b0;
    logic            exp_ill = 1'b0;
    logic [3:0]      last_op = 4'd0;
    logic [RA_W-1:0] last_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {legal, use_rs1, use_rs2, reg_write, mem_write, is_div}
    function automatic logic [5:0] ref_decode(input logic [3:0] op);
        case (op)
            4'h0:                   return 6'b110100;
            4'h1:                   return 6'b111010;
            4'h2:                   return 6'b100100;
            4'h3, 4'h6, 4'h8, 4'h9: return 6'b110100;
            4'h4, 4'h5, 4'h7,
            4'hA, 4'hB:             return 6'b111100;
            4'hC:                   return 6'b111101;
            default:                return 6'b000000;
        endcase
    endfunction

    task automatic set_instr(input logic v, input logic [3:0] op, input int rd, input int rs1, input int rs2);
        id_valid  = v;
        id_opcode = op;
        id_rd     = RA_W'(rd);
        id_rs1    = RA_W'(rs1);
        id_rs2    = RA_W'(rs2);
    endtask

    task automatic set_wb(input logic v, input int rd);
        wb_valid = v;
        wb_rd    = RA_W'(rd);
    endtask

    task automatic cycle();
        ex_exp_t    e;
        logic [5:0] d;
        logic       ready;
        logic       acc;
        @(negedge clk);
        if (exp_ex) begin
            check_eq("ex_valid", 32'(ex_valid), 32'd1);
            if (exq.size() == 0) begin
                check_eq("ex_queue_empty", 32'd0, 32'd1);
            end else begin
                e = exq.pop_front();
                check_eq("ex_opcode", 32'(ex_opcode), 32'(e.op));
                check_eq("ex_rd", 32'(ex_rd), 32'(e.rd));
                check_eq("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
                check_eq("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
                last_op = e.op;
                last_rd = e.rd;
            end
        end else begin
            check_eq("ex_valid_idle", 32'(ex_valid), 32'd0);
            check_eq("ex_reg_write_idle", 32'(ex_reg_write), 32'd0);
            check_eq("ex_mem_write_idle", 32'(ex_mem_write), 32'd0);
            check_eq("ex_opcode_hold", 32'(ex_opcode), 32'(last_op));
            check_eq("ex_rd_hold", 32'(ex_rd), 32'(last_rd));
        end
        check_eq("illegal_op", 32'(illegal_op), 32'(exp_ill));
        check_eq("div_busy", 32'(div_busy), 32'(div_left != 0));

        d = ref_decode(id_opcode);
        ready = (div_left == 0)
              && !(d[4] && pend[id_rs1])
              && !(d[3] && pend[id_rs2])
              && !(d[2] && pend[id_rd]);
        check_eq("id_ready", 32'(id_ready), 32'(ready));

        if (div_left != 0) div_left--;
        acc     = id_valid && ready;
        exp_ex  = acc && d[5];
        exp_ill = acc && !d[5];
        if (wb_valid) pend[wb_rd] = 1'b0;
        if (exp_ex) begin
            e.op = id_opcode;
            e.rd = id_rd;
            e.rw = d[2];
            e.mw = d[1];
            exq.push_back(e);
            if (d[2]) pend[id_rd] = 1'b1;
            if (d[0]) div_left = DIV_CYCLES - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst_ex_opcode", 32'(ex_opcode), 32'd0);
        check_eq("rst_ex_rd", 32'(ex_rd), 32'd0);
        check_eq("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        check_eq("rst_ex_mem_write", 32'(ex_mem_write), 32'd0);
        check_eq("rst_illegal_op", 32'(illegal_op), 32'd0);
        check_eq("rst_div_busy", 32'(div_busy), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pend     = '0;
        div_left = 0;
        exp_ex   = 1'b0;
        exp_ill  = 1'b0;
        last_op  = 4'd0;
        last_rd  = '0;
        exq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_instr(1'b0, 4'h0, 0, 0, 0);
        set_wb(1'b0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // add r1,r2,r3 issues directly out of reset
        set_instr(1'b1, 4'hA, 1, 2, 3); cycle();
        // sub r4,r1,r2 stalls on r1 until the cycle after its writeback
        set_instr(1'b1, 4'hB, 4, 1, 2); cycle(); cycle();
        set_wb(1'b1, 1); cycle();
        set_wb(1'b0, 0); cycle();
        set_instr(1'b0, 4'h0, 0, 0, 0); cycle();

        // div r5,r6,r7 then mov r0,r1 waits out the occupancy
        set_instr(1'b1, 4'hC, 5, 6, 7); cycle();
        set_instr(1'b1, 4'h3, 0, 1, 0);
        for (int i = 0; i < DIV_CYCLES; i++) cycle();
        set_instr(1'b0, 4'h0, 0, 0, 0); cycle();

        // illegal opcode targeting a pending rd is dropped without stalling
        set_instr(1'b1, 4'hE, 4, 4, 4); cycle();
        set_instr(1'b1, 4'hF, 0, 5, 5); cycle();
        set_instr(1'b0, 4'h0, 0, 0, 0); cycle();

        // retire r0/r4/r5, plus a writeback to an idle register
        set_wb(1'b1, 0); cycle();
        set_wb(1'b1, 4); cycle();
        set_wb(1'b1, 5); cycle();
        set_wb(1'b1, 7); cycle();
        set_wb(1'b0, 0);

        // stm r0,r2 with r2 pending; stm must not mark r3
        set_instr(1'b1, 4'h2, 2, 0, 0); cycle();
        set_instr(1'b1, 4'h1, 3, 0, 2); cycle(); cycle();
        set_wb(1'b1, 2); cycle();
        set_wb(1'b0, 0); cycle();
        set_instr(1'b1, 4'hA, 6, 3, 3); cycle();
        // WAW on r6
        set_instr(1'b1, 4'h2, 6, 0, 0); cycle(); cycle();
        set_wb(1'b1, 6); cycle();
        set_wb(1'b0, 0); cycle();
        set_instr(1'b0, 4'h0, 0, 0, 0); cycle();

        // reset in the middle of a div with r3 pending
        do_reset();
        set_instr(1'b1, 4'h2, 3, 0, 0); cycle();
        set_instr(1'b1, 4'hC, 1, 2, 2); cycle();
        set_instr(1'b0, 4'h0, 0, 0, 0); cycle();
        do_reset();
        set_instr(1'b1, 4'hA, 3, 3, 3); cycle();
        set_instr(1'b0, 4'h0, 0, 0, 0); cycle();

        // mixed traffic
        for (int i = 0; i < 150; i++) begin
            set_instr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                      int'($urandom_range(0, NREG - 1)));
            set_wb(1'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)));
            cycle();
        end
        set_instr(1'b0, 4'h0, 0, 0, 0);
        set_wb(1'b0, 0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
